bus_stim_gen: RTL and testbench
===============================

Name: bus_stim_gen

Overview:
Upstream stimulus stage for the registered bus-capture block (CLK, A, B[3:0], C[7:0], D[31:0]).
- Generates a deterministic, programmable-length sequence of vectors on the four buses.
- One vector per clock while running; it can be paused, and it reports completion.
- Bus outputs are registered so they can drive the capture stage directly with no combinational path.

Parameters:
NUM_VECTORS, 16, vectors per run; legal range 1..65535
B_STEP, 1, increment applied to B per vector, modulo 16 (4-bit)
LFSR_SEED, 32'h0000_0001, D value for vector 0; must be nonzero

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous, active-high reset
START  in  1  begin a run; sampled at rising edge of CLK
PAUSE  in  1  hold the sequence while high
A  out  1  vector bit A
B  out  4  vector bus B
C  out  8  vector bus C
D  out  32  vector bus D
VALID  out  1  A/B/C/D hold a newly issued vector this cycle
BUSY  out  1  high while in RUN
DONE  out  1  run complete; sticky until next START or RST
COUNT  out  16  number of vectors issued in the current run

Behaviour:
- One clock, CLK. RST is asynchronous and active-high.
- RST asserted, any time including mid-run, sets all of the following immediately:
  - state IDLE
  - A=0, B=0, C=0, D=0
  - VALID=0, BUSY=0, DONE=0, COUNT=0
  - internal LFSR reloaded to LFSR_SEED
- Vector k, 0-based:
  - A = k[0]
  - B = (k*B_STEP) mod 16
  - C = 8'h01 << (k mod 8)
  - D = LFSR state after k steps from LFSR_SEED
- LFSR step: 32-bit Galois, right shift. next = (cur>>1) ^ (cur[0] ? 32'h8020_0003 : 0).
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE or DONE, START=1:
  - outputs load vector 0; VALID<=1, COUNT<=1, BUSY<=1, DONE<=0
  - go to RUN
  - LFSR restarts from LFSR_SEED on every START
- IDLE or DONE, START=0: outputs hold, VALID<=0.
- RUN, PAUSE=1:
  - A/B/C/D and COUNT hold; VALID<=0; stay in RUN
  - LFSR does not advance
- RUN, PAUSE=0, COUNT<NUM_VECTORS: load vector COUNT; COUNT<=COUNT+1; VALID<=1.
- RUN, PAUSE=0, COUNT==NUM_VECTORS:
  - VALID<=0, BUSY<=0, DONE<=1; go to DONE
  - A/B/C/D hold the last vector
- PAUSE takes priority over completion: a paused run never ends while PAUSE=1.
- START during RUN is ignored, with no restart and no glitch on the outputs.
- START and PAUSE both high in IDLE/DONE: START wins. Vector 0 issues; PAUSE takes effect from the next edge.
- Latency: START sampled at edge n produces vector 0 with VALID=1 after edge n. With no pause, the last vector appears after edge n+NUM_VECTORS-1 and DONE rises after edge n+NUM_VECTORS.
- Wrap-around:
  - B wraps modulo 16; C wraps every 8 vectors.
  - COUNT never exceeds NUM_VECTORS, so no 16-bit overflow.
- NUM_VECTORS=1: vector 0 issues, and DONE rises on the next unpaused edge.

Test Plan:
- Reset: assert RST asynchronously between edges -> all outputs 0 without waiting for a CLK edge; BUSY=0, DONE=0.
- Default run, START for 1 cycle -> across four consecutive cycles, all with VALID=1:
  - A = 0,1,0,1
  - B = 0,1,2,3
  - C = 01,02,04,08
  - D = 00000001, 80200003, C0300002, 60180001
- Completion, NUM_VECTORS=16:
  - 16th vector shows A=1, B=F, C=80, COUNT=16
  - next edge: VALID=0, BUSY=0, DONE=1; buses hold
  - with NUM_VECTORS=20: vector 16 shows B=0, C=01
- Pause: PAUSE=1 for 3 cycles after vector 2 (D=C0300002) -> VALID=0 for 3 cycles with buses and COUNT=3 held; after release the next vector is D=60180001 with VALID=1.
- Reset mid-run: RST after vector 5 -> immediate return to IDLE with outputs 0; a following START restarts at vector 0 with D=00000001.
- START handling:
  - START pulsed during RUN -> sequence unaffected, COUNT continues
  - START in DONE -> DONE clears on that edge, vector 0 issues, COUNT=1

Source files
------------

// File: rtl/bus_stim_gen_if.sv
// bus_stim_gen_if: control inputs and registered vector outputs of the stimulus generator
//    master (the generator) : takes start, pause; drives a, b, c, d, valid, busy, done, count
//    slave  (the consumer)  : drives start, pause; takes the vector buses and status
interface bus_stim_gen_if;
   logic        start;
   logic        pause;
   logic        a;
   logic [3:0]  b;
   logic [7:0]  c;
   logic [31:0] d;
   logic        valid;
   logic        busy;
   logic        done;
   logic [15:0] count;
   modport master (input start, pause, output a, b, c, d, valid, busy, done, count);
   modport slave  (output start, pause, input a, b, c, d, valid, busy, done, count);
endinterface

// File: rtl/bus_stim_gen.sv
// bus_stim_gen: issues a run of NUM_VECTORS deterministic vectors, one per unpaused clock
//    clk : rising-edge clock
//    rst : asynchronous active-high reset
//    bus : start/pause in; registered a/b/c/d vector, valid, busy, done, count out
module bus_stim_gen #(
   parameter int          NUM_VECTORS = 16,
   parameter int          B_STEP      = 1,
   parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
   input  logic              clk,
   input  logic              rst,
   bus_stim_gen_if.master    bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t      state, state_n;
   logic        a_n, valid_n, busy_n, done_n;
   logic [3:0]  b_n;
   logic [7:0]  c_n;
   logic [31:0] d_n;
   logic [15:0] count_n;
   // d always holds the LFSR state of the vector on the bus, so stepping it yields the next one
   function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
      return (cur >> 1) ^ (cur[0] ? 32'h8020_0003 : 32'h0);
   endfunction
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         bus.a     <= 1'b0;
         bus.b     <= '0;
         bus.c     <= '0;
         bus.d     <= '0;
         bus.valid <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.count <= '0;
      end else begin
         state     <= state_n;
         bus.a     <= a_n;
         bus.b     <= b_n;
         bus.c     <= c_n;
         bus.d     <= d_n;
         bus.valid <= valid_n;
         bus.busy  <= busy_n;
         bus.done  <= done_n;
         bus.count <= count_n;
      end
   always_comb begin
      state_n = state;
      a_n     = bus.a;
      b_n     = bus.b;
      c_n     = bus.c;
      d_n     = bus.d;
      valid_n = 1'b0;
      busy_n  = bus.busy;
      done_n  = bus.done;
      count_n = bus.count;
      case (state)
         RUN:
            // pause outranks completion, so a paused run can never finish
            if (!bus.pause) begin
               if (bus.count < 16'(NUM_VECTORS)) begin
                  a_n     = bus.count[0];
                  b_n     = bus.b + 4'(B_STEP);
                  c_n     = {bus.c[6:0], bus.c[7]};
                  d_n     = lfsr_step(bus.d);
                  valid_n = 1'b1;
                  count_n = bus.count + 16'd1;
               end else begin
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = FIN;
               end
            end
         default:
            if (bus.start) begin
               a_n     = 1'b0;
               b_n     = '0;
               c_n     = 8'h01;
               d_n     = LFSR_SEED;
               valid_n = 1'b1;
               busy_n  = 1'b1;
               done_n  = 1'b0;
               count_n = 16'd1;
               state_n = RUN;
            end
      endcase
   end
endmodule

// File: tb/tb_bus_stim_gen.sv
// tb_bus_stim_gen: directed checks of bus_stim_gen with 16-, 20- and 1-vector runs
module tb_bus_stim_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   bus_stim_gen_if u16 ();
   bus_stim_gen_if u20 ();
   bus_stim_gen_if u1 ();
   bus_stim_gen #(.NUM_VECTORS(16)) dut16 (.clk(clk), .rst(rst), .bus(u16));
   bus_stim_gen #(.NUM_VECTORS(20)) dut20 (.clk(clk), .rst(rst), .bus(u20));
   bus_stim_gen #(.NUM_VECTORS(1))  dut1  (.clk(clk), .rst(rst), .bus(u1));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   task automatic chk_vec(input string tag, input logic [31:0] a, b, c, d, valid, count);
      chk({tag, ".a"}, 32'(u16.a), a);
      chk({tag, ".b"}, 32'(u16.b), b);
      chk({tag, ".c"}, 32'(u16.c), c);
      chk({tag, ".d"}, u16.d, d);
      chk({tag, ".valid"}, 32'(u16.valid), valid);
      chk({tag, ".count"}, 32'(u16.count), count);
   endtask
   task automatic chk_zero(input string tag);
      chk_vec(tag, 0, 0, 0, 0, 0, 0);
      chk({tag, ".busy"}, 32'(u16.busy), 0);
      chk({tag, ".done"}, 32'(u16.done), 0);
   endtask
   initial begin
      u16.start = 0; u16.pause = 0;
      u20.start = 0; u20.pause = 0;
      u1.start = 0;  u1.pause = 0;
      tick(); tick();
      chk_zero("por");
      rst = 0;
      // default run
      u16.start = 1; tick(); u16.start = 0;
      chk_vec("v0", 0, 0, 32'h01, 32'h0000_0001, 1, 1);
      chk("v0.busy", 32'(u16.busy), 1);
      tick(); chk_vec("v1", 1, 1, 32'h02, 32'h8020_0003, 1, 2);
      tick(); chk_vec("v2", 0, 2, 32'h04, 32'hC030_0002, 1, 3);
      // pause for three cycles after vector 2
      u16.pause = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_vec("pause", 0, 2, 32'h04, 32'hC030_0002, 0, 3);
      end
      u16.pause = 0;
      tick(); chk_vec("v3", 1, 3, 32'h08, 32'h6018_0001, 1, 4);
      // start during run is ignored
      u16.start = 1; tick(); u16.start = 0;
      chk_vec("v4", 0, 4, 32'h10, 32'hB02C_0003, 1, 5);
      repeat (11) tick();
      chk_vec("v15", 1, 15, 32'h80, u16.d, 1, 16);
      chk("v15.busy", 32'(u16.busy), 1);
      chk("v15.done", 32'(u16.done), 0);
      tick(); chk_vec("fin", 1, 15, 32'h80, u16.d, 0, 16);
      chk("fin.busy", 32'(u16.busy), 0);
      chk("fin.done", 32'(u16.done), 1);
      tick(); chk("fin2.done", 32'(u16.done), 1);
      chk("fin2.valid", 32'(u16.valid), 0);
      // start from done
      u16.start = 1; tick(); u16.start = 0;
      chk_vec("re0", 0, 0, 32'h01, 32'h0000_0001, 1, 1);
      chk("re0.done", 32'(u16.done), 0);
      chk("re0.busy", 32'(u16.busy), 1);
      repeat (5) tick();
      chk_vec("re5", 1, 5, 32'h20, u16.d, 1, 6);
      // asynchronous reset mid-run, between edges
      #2 rst = 1;
      #1 chk_zero("arst");
      #1 rst = 0;
      tick(); chk_zero("idle");
      // start and pause together: start wins, pause applies next edge
      u16.start = 1; u16.pause = 1; tick(); u16.start = 0;
      chk_vec("sp0", 0, 0, 32'h01, 32'h0000_0001, 1, 1);
      tick(); chk_vec("sp1", 0, 0, 32'h01, 32'h0000_0001, 0, 1);
      chk("sp1.busy", 32'(u16.busy), 1);
      u16.pause = 0;
      tick(); chk_vec("sp2", 1, 1, 32'h02, 32'h8020_0003, 1, 2);
      // 20-vector run: wrap of b and c at vector 16
      u20.start = 1; tick(); u20.start = 0;
      repeat (16) tick();
      chk("w16.a", 32'(u20.a), 0);
      chk("w16.b", 32'(u20.b), 0);
      chk("w16.c", 32'(u20.c), 32'h01);
      chk("w16.count", 32'(u20.count), 17);
      chk("w16.valid", 32'(u20.valid), 1);
      repeat (3) tick();
      chk("w19.count", 32'(u20.count), 20);
      chk("w19.done", 32'(u20.done), 0);
      tick();
      chk("w20.done", 32'(u20.done), 1);
      chk("w20.count", 32'(u20.count), 20);
      // single-vector run
      u1.start = 1; tick(); u1.start = 0;
      chk("n1.valid", 32'(u1.valid), 1);
      chk("n1.count", 32'(u1.count), 1);
      chk("n1.done0", 32'(u1.done), 0);
      tick();
      chk("n1.done", 32'(u1.done), 1);
      chk("n1.busy", 32'(u1.busy), 0);
      chk("n1.valid2", 32'(u1.valid), 0);
      chk("n1.d", u1.d, 32'h0000_0001);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
